// File: rtl/servo_pwm_sched.sv
// servo_pwm_sched: multi-channel servo pulse scheduler.
// One PWM frame of PERIOD_TICKS cycles drives all channels. The first N_CH
// cycles of every frame after the first form the update window: in slot k,
// channel k moves its active width toward its target.
// Build macro SERVO_SLEW_EN: when defined, each update moves at most slew_step
// ticks; when undefined, each update jumps straight to the target and
// slew_step is ignored. FSM timing and cfg_ready are the same in both builds.
//
// state | meaning
// IDLE  | disabled, outputs low, cnt held at 0
// RUN   | frame in progress, cnt counting
// UPD   | update window, slot k = channel k, cnt still counting
module servo_pwm_sched #(
  parameter int N_CH         = 4,
  parameter int W            = 18,
  parameter int PERIOD_TICKS = 2_000_000,
  parameter int MIN_TICKS    = 100_000,
  parameter int MAX_TICKS    = 200_000,
  parameter int CENTER_TICKS = 150_000,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W       = $clog2(PERIOD_TICKS)
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_target,
  input  logic [15:0]     slew_step,
  output logic [N_CH-1:0] pwm_out,
  output logic            frame_start,
  output logic [N_CH-1:0] at_target,
  output logic            cfg_err
);

  localparam int CMP_W = (CNT_W > W) ? CNT_W : W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CH_W-1:0]  K_LAST   = CH_W'(N_CH - 1);
  localparam logic [W-1:0]     MIN_W    = W'(MIN_TICKS);
  localparam logic [W-1:0]     MAX_W    = W'(MAX_TICKS);
  localparam logic [W-1:0]     CENTER_W = W'(CENTER_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, UPD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   k_q, k_d;
  logic [W-1:0]      cur_q [N_CH];
  logic [W-1:0]      cur_d [N_CH];
  logic [W-1:0]      tgt_q [N_CH];
  logic [W-1:0]      tgt_d [N_CH];

  logic [N_CH-1:0]   pwm_q, pwm_d;
  logic [N_CH-1:0]   at_target_q, at_target_d;
  logic              frame_start_q, cfg_ready_q, cfg_err_q;

  logic              cfg_accept;
  logic              cfg_oor;
  logic [W-1:0]      cfg_clamped;
  logic [W-1:0]      upd_cur, upd_tgt, upd_next;

  assign cfg_accept = cfg_valid & cfg_ready_q;

  // Clamp the requested width into the legal servo range and flag clamping.
  always_comb begin
    cfg_oor     = 1'b1;
    cfg_clamped = cfg_target;
    if (cfg_target < MIN_W) begin
      cfg_clamped = MIN_W;
    end else if (cfg_target > MAX_W) begin
      cfg_clamped = MAX_W;
    end else begin
      cfg_oor = 1'b0;
    end
  end

`ifdef SERVO_SLEW_EN
  logic signed [W:0] diff;
  logic [W:0]        mag;
  logic [W:0]        step_ext;

  // Slew-limited next width for the channel owning the current update slot.
  // Result always lies between cur and target, so it stays in range.
  always_comb begin
    upd_cur  = cur_q[k_q];
    upd_tgt  = tgt_q[k_q];
    diff     = $signed({1'b0, upd_tgt}) - $signed({1'b0, upd_cur});
    mag      = diff[W] ? (W+1)'(-diff) : (W+1)'(diff);
    step_ext = (W+1)'(slew_step);
    if (mag <= step_ext) begin
      upd_next = upd_tgt;
    end else if (diff[W]) begin
      upd_next = upd_cur - step_ext[W-1:0];
    end else begin
      upd_next = upd_cur + step_ext[W-1:0];
    end
  end
`else
  logic unused_slew;
  assign unused_slew = ^slew_step;

  // Without slew limiting the update slot copies the target directly.
  always_comb begin
    upd_cur  = cur_q[k_q];
    upd_tgt  = tgt_q[k_q];
    upd_next = (upd_cur == upd_tgt) ? upd_cur : upd_tgt;
  end
`endif

  // Frame FSM, counter, target writes and per-slot width update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;

    for (int i = 0; i < N_CH; i++) begin
      if (cfg_accept && (cfg_ch == CH_W'(i))) tgt_d[i] = cfg_clamped;
    end

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            k_d     = '0;
            state_d = UPD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        UPD: begin
          cnt_d = cnt_q + 1'b1;
          for (int i = 0; i < N_CH; i++) begin
            if (k_q == CH_W'(i)) cur_d[i] = upd_next;
          end
          if (k_q == K_LAST) begin
            state_d = RUN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: pulse level from the present count, status from next state.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i]       = enable && (state_q != IDLE) &&
                       (CMP_W'(cnt_q) < CMP_W'(cur_q[i]));
      at_target_d[i] = (cur_d[i] == tgt_d[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      k_q           <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i] <= CENTER_W;
        tgt_q[i] <= CENTER_W;
      end
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      at_target_q   <= '1;
      cfg_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      cur_q         <= cur_d;
      tgt_q         <= tgt_d;
      pwm_q         <= pwm_d;
      frame_start_q <= (state_d != IDLE) && (cnt_d == '0);
      cfg_err_q     <= cfg_accept && cfg_oor;
      at_target_q   <= at_target_d;
      cfg_ready_q   <= (state_d != UPD);
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign at_target   = at_target_q;
  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_servo_pwm_sched.sv
// Bench for servo_pwm_sched with a short frame. A monitor measures every
// channel's pulse width per frame and compares it against widths the stimulus
// side predicted and queued at each frame start.
module tb_servo_pwm_sched;
  localparam int N_CH     = 4;
  localparam int W        = 18;
  localparam int P        = 1000;
  localparam int MIN_T    = 100;
  localparam int MAX_T    = 200;
  localparam int CEN      = 150;
  localparam int WAIT_MAX = 2 * P + 10;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic            enable;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [W-1:0]    cfg_target;
  logic [15:0]     slew_step;
  logic [N_CH-1:0] pwm_out;
  logic            frame_start;
  logic [N_CH-1:0] at_target;
  logic            cfg_err;

  int n_checks = 0;
  int n_errors = 0;
  int m_cur [N_CH];
  int m_tgt [N_CH];
  int exp_q [$];
  bit mon_en = 1'b0;
  bit have_frame = 1'b0;

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] tgt;
    int           exp_tgt;
    bit           exp_err;
  } cfg_vec_t;
  cfg_vec_t vecs [13];

  servo_pwm_sched #(
    .N_CH(N_CH), .W(W), .PERIOD_TICKS(P),
    .MIN_TICKS(MIN_T), .MAX_TICKS(MAX_T), .CENTER_TICKS(CEN)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_target(cfg_target), .slew_step(slew_step), .pwm_out(pwm_out),
    .frame_start(frame_start), .at_target(at_target), .cfg_err(cfg_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic int slew_model(int cur, int tgt, int step);
    int d = tgt - cur;
    bit snap = (d <= step) && (-d <= step);
`ifndef SERVO_SLEW_EN
    snap = 1'b1;
`endif
    if (snap) return tgt;
    return (d > 0) ? cur + step : cur - step;
  endfunction

  function automatic logic [N_CH-1:0] model_at();
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = (m_cur[k] == m_tgt[k]);
    return r;
  endfunction

  task automatic model_update();
    for (int k = 0; k < N_CH; k++) m_cur[k] = slew_model(m_cur[k], m_tgt[k], int'(slew_step));
  endtask

  task automatic push_exp();
    for (int k = 0; k < N_CH; k++) exp_q.push_back(m_cur[k]);
  endtask

  task automatic wait_fs(output int waited);
    waited = 0;
    while (!frame_start && waited < WAIT_MAX) begin
      tick();
      waited++;
    end
    if (!frame_start) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_start_timeout: none within %0d cycles", waited);
    end
  endtask

  task automatic cfg_write(input int ch, input int tgt);
    int waited = 0;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_target = W'(tgt);
    while (!cfg_ready && waited < N_CH + 4) begin
      tick();
      waited++;
    end
    if (!cfg_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL cfg_ready_timeout: ready low for %0d cycles", waited);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  // Run n measured frames; ends N_CH cycles after the following frame start.
  task automatic run_frames(input int n, input bit from_idle);
    int waited;
    mon_en = 1'b1;
    for (int f = 0; f < n; f++) begin
      wait_fs(waited);
      if (f == 0 && from_idle) begin
        check("restart_latency", waited, 1);
        check("ready_first_frame", cfg_ready, 1);
      end else begin
        model_update();
        check("ready_upd_slot", cfg_ready, 0);
      end
      push_exp();
      repeat (N_CH) tick();
      check("at_target", at_target, model_at());
    end
    wait_fs(waited);
    model_update();
    repeat (N_CH) tick();
    mon_en = 1'b0;
    have_frame = 1'b0;
  endtask

  initial begin : monitor
    int hi [N_CH];
    int len;
    int e;
    len = 0;
    for (int i = 0; i < N_CH; i++) hi[i] = 0;
    forever begin
      @(posedge ACLK);
      #2;
      if (mon_en) begin
        if (frame_start) begin
          if (have_frame) begin
            check("frame_len", len, P);
            for (int i = 0; i < N_CH; i++) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL width_ch%0d: measured %0d with no prediction queued", i, hi[i]);
              end else begin
                e = exp_q.pop_front();
                check($sformatf("width_ch%0d", i), hi[i], e);
              end
            end
          end
          have_frame = 1'b1;
          len = 0;
          for (int i = 0; i < N_CH; i++) hi[i] = 0;
        end
        if (have_frame) begin
          len++;
          for (int i = 0; i < N_CH; i++) hi[i] += int'(pwm_out[i]);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecs[0]  = '{2'd1, 18'd250,    200, 1'b1};
    vecs[1]  = '{2'd2, 18'd250,    200, 1'b1};
    vecs[2]  = '{2'd2, 18'd50,     100, 1'b1};
    vecs[3]  = '{2'd3, 18'd100,    100, 1'b0};
    vecs[4]  = '{2'd3, 18'd99,     100, 1'b1};
    vecs[5]  = '{2'd0, 18'd200,    200, 1'b0};
    vecs[6]  = '{2'd0, 18'd201,    200, 1'b1};
    vecs[7]  = '{2'd0, 18'd262143, 200, 1'b1};
    vecs[8]  = '{2'd1, 18'd0,      100, 1'b1};
    vecs[9]  = '{2'd0, 18'd150,    150, 1'b0};
    vecs[10] = '{2'd1, 18'd150,    150, 1'b0};
    vecs[11] = '{2'd2, 18'd150,    150, 1'b0};
    vecs[12] = '{2'd3, 18'd150,    150, 1'b0};

    ARESETN = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_target = '0; slew_step = 16'd2;
    for (int k = 0; k < N_CH; k++) begin m_cur[k] = CEN; m_tgt[k] = CEN; end

    repeat (3) tick();
    check("rst_pwm", pwm_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_at_target", at_target, 4'hF);
    check("rst_cfg_ready", cfg_ready, 0);
    ARESETN = 1'b1;
    tick();
    check("idle_cfg_ready", cfg_ready, 1);
    check("idle_pwm", pwm_out, 0);

    // Target writes in IDLE: clamping, error pulse, at_target
    foreach (vecs[v]) begin
      cfg_write(int'(vecs[v].ch), int'(vecs[v].tgt));
      m_tgt[vecs[v].ch] = vecs[v].exp_tgt;
      check($sformatf("cfg_err_v%0d", v), cfg_err, vecs[v].exp_err);
      check($sformatf("cfg_at_target_v%0d", v), at_target, model_at());
      tick();
      check($sformatf("cfg_err_clear_v%0d", v), cfg_err, 0);
    end

    // Free-running frames at center width
    enable = 1'b1;
    run_frames(2, 1'b1);

    // Slewed move of channel 1
    cfg_write(1, 160);
    m_tgt[1] = 160;
    check("t2_cfg_err", cfg_err, 0);
    run_frames(6, 1'b0);

    // Write at the last count of a frame, then a held request across the window
    repeat (P - 1 - N_CH) tick();
    check("t4_ready_at_last", cfg_ready, 1);
    check("t4_no_fs_at_last", frame_start, 0);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_target = W'(180);
    tick();
    m_tgt[0] = 180;
    check("t4_frame_start", frame_start, 1);
    check("t4_ready_cnt0", cfg_ready, 0);
    cfg_ch = 2'd3; cfg_target = W'(120);
    model_update();
    push_exp();
    mon_en = 1'b1;
    for (int c = 1; c < N_CH; c++) begin
      tick();
      check($sformatf("t4_ready_cnt%0d", c), cfg_ready, 0);
    end
    tick();
    check("t4_ready_cnt4", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    m_tgt[3] = 120;
    check("t4_at_target", at_target, model_at());
    run_frames(2, 1'b0);

    // Zero step freezes (slew build); large step snaps to target
    slew_step = 16'd0;
    cfg_write(0, 100);
    m_tgt[0] = 100;
    run_frames(2, 1'b0);
    slew_step = 16'd1000;
    run_frames(1, 1'b0);
    slew_step = 16'd2;

    // Disable mid-pulse, then re-enable with retained widths
    repeat (60 - N_CH) tick();
    check("t5_pwm_before", pwm_out, 4'hF);
    enable = 1'b0;
    tick();
    check("t5_pwm_off", pwm_out, 0);
    check("t5_fs_off", frame_start, 0);
    check("t5_ready_idle", cfg_ready, 1);
    repeat (10) tick();
    check("t5_pwm_stays_off", pwm_out, 0);
    enable = 1'b1;
    run_frames(2, 1'b1);

    // Asynchronous reset mid-frame restores center widths
    repeat (50 - N_CH) tick();
    check("t6_pwm_before", pwm_out, 4'hF);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_pwm_async", pwm_out, 0);
    check("t6_at_target_async", at_target, 4'hF);
    check("t6_ready_async", cfg_ready, 0);
    check("t6_fs_async", frame_start, 0);
    for (int k = 0; k < N_CH; k++) begin m_cur[k] = CEN; m_tgt[k] = CEN; end
    repeat (2) tick();
    ARESETN = 1'b1;
    run_frames(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
